// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences the datapath,
// drives mux selects / write enables, and traps on bad opcodes or bus stalls.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic             illegal_inst,
    output logic             bus_error
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit TO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LIM =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              mem_wait;
    logic              timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            wait_q    <= '0;
            retire_q  <= 1'b0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        retire_d      = 1'b0;
        mem_wait      = 1'b0;
        timeout       = TO_EN && (wait_q == WAIT_LIM) && !mem_ready;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        trap          = 1'b0;

        unique case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                mem_wait  = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:     state_d = S_EXEC_R;
                    OP_I:     state_d = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE: state_d = S_MEM_ADDR;
                    OP_BR:    state_d = S_BRANCH;
                    OP_JAL:   state_d = S_JAL;
                    OP_JALR:  state_d = S_JALR;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_AUIPC;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 3'b010;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
                alu_op    = 3'b100;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_op    = 3'b101;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire_d  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_wait = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire_d   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_wait  = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire_d      = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b01;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                retire_d   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                retire_d   = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_INIT;
        endcase

        // counter restarts on every state change, so entry always starts at 0
        wait_d = '0;
        if (mem_wait && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        instret_d = instret_q + CNT_W'(retire_d);
    end

    assign retire       = retire_q;
    assign instret      = instret_q;
    assign illegal_inst = illegal_q;
    assign bus_error    = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-opcode micro-op plan model checked every
// cycle, plus literal spot checks of latency, timeout and reset behaviour.
module tb_multicycle_control;

    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        bit    waits;
        bit    retires;
        bit    is_decode;
        bit    is_fetch;
    } step_t;

    typedef struct packed {
        ctrl_t          c;
        logic           retire;
        logic [CW-1:0]  instret;
        logic           trap;
        logic           ill;
        logic           bus;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic          pc_write_cond, reg_write, retire, trap;
    logic          illegal_inst, bus_error;
    logic [1:0]    pc_source, alu_src_a, alu_src_b, mem_to_reg;
    logic [2:0]    alu_op;
    logic [CW-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .instret(instret), .trap(trap), .illegal_inst(illegal_inst),
        .bus_error(bus_error)
    );

    ctrl_t dut_c;
    assign dut_c = {mem_read, mem_write, i_or_d, ir_write, pc_write,
                    pc_write_cond, pc_source, alu_src_a, alu_src_b,
                    alu_op, reg_write, mem_to_reg};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Micro-op table: what each step of an instruction drives
    function automatic step_t st(input string n);
        step_t s;
        s.c = '0;
        s.waits = 1'b0;
        s.retires = 1'b0;
        s.is_decode = 1'b0;
        s.is_fetch = 1'b0;
        case (n)
            "FETCH": begin
                s.c.mem_read = 1'b1; s.c.src_b = 2'b01;
                s.waits = 1'b1; s.is_fetch = 1'b1;
            end
            "DECODE": begin
                s.c.src_a = 2'b10; s.c.src_b = 2'b10; s.is_decode = 1'b1;
            end
            "EXEC_R": begin s.c.src_a = 2'b01; s.c.alu_op = 3'b010; end
            "EXEC_I": begin
                s.c.src_a = 2'b01; s.c.src_b = 2'b10; s.c.alu_op = 3'b011;
            end
            "LUI": begin
                s.c.src_a = 2'b11; s.c.src_b = 2'b10; s.c.alu_op = 3'b100;
            end
            "AUIPC": begin
                s.c.src_a = 2'b10; s.c.src_b = 2'b10; s.c.alu_op = 3'b101;
            end
            "ALU_WB": begin s.c.reg_write = 1'b1; s.retires = 1'b1; end
            "MEM_ADDR": begin s.c.src_a = 2'b01; s.c.src_b = 2'b10; end
            "MEM_READ": begin
                s.c.mem_read = 1'b1; s.c.i_or_d = 1'b1; s.waits = 1'b1;
            end
            "MEM_WB": begin
                s.c.reg_write = 1'b1; s.c.mem_to_reg = 2'b01;
                s.retires = 1'b1;
            end
            "MEM_WRITE": begin
                s.c.mem_write = 1'b1; s.c.i_or_d = 1'b1;
                s.waits = 1'b1; s.retires = 1'b1;
            end
            "BRANCH": begin
                s.c.src_a = 2'b01; s.c.alu_op = 3'b001;
                s.c.pc_write_cond = 1'b1; s.c.pc_source = 2'b01;
                s.retires = 1'b1;
            end
            "JAL": begin
                s.c.pc_write = 1'b1; s.c.pc_source = 2'b01;
                s.c.reg_write = 1'b1; s.c.mem_to_reg = 2'b10;
                s.retires = 1'b1;
            end
            "JALR": begin
                s.c.src_a = 2'b01; s.c.src_b = 2'b10; s.c.pc_write = 1'b1;
                s.c.reg_write = 1'b1; s.c.mem_to_reg = 2'b10;
                s.retires = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    step_t plan[$];
    bit    m_halt, m_ill, m_bus, m_ret;
    int    m_wait, m_cnt;

    task automatic expand(input logic [6:0] op, output bit bad);
        bad = 1'b0;
        case (op)
            7'b0110011: begin plan.push_back(st("EXEC_R")); plan.push_back(st("ALU_WB")); end
            7'b0010011: begin plan.push_back(st("EXEC_I")); plan.push_back(st("ALU_WB")); end
            7'b0110111: begin plan.push_back(st("LUI")); plan.push_back(st("ALU_WB")); end
            7'b0010111: begin plan.push_back(st("AUIPC")); plan.push_back(st("ALU_WB")); end
            7'b0000011: begin
                plan.push_back(st("MEM_ADDR"));
                plan.push_back(st("MEM_READ"));
                plan.push_back(st("MEM_WB"));
            end
            7'b0100011: begin
                plan.push_back(st("MEM_ADDR"));
                plan.push_back(st("MEM_WRITE"));
            end
            7'b1100011: plan.push_back(st("BRANCH"));
            7'b1101111: plan.push_back(st("JAL"));
            7'b1100111: plan.push_back(st("JALR"));
            default: bad = 1'b1;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        step_t s;
        bit done, bad;
        if (!rst_n) begin
            plan.delete();
            plan.push_back(st("INIT"));
            m_halt = 1'b0; m_ill = 1'b0; m_bus = 1'b0; m_ret = 1'b0;
            m_wait = 0; m_cnt = 0;
        end else begin
            m_ret = 1'b0;
            if (!m_halt) begin
                s = plan[0];
                done = 1'b0;
                if (!s.waits || mem_ready) begin
                    done = 1'b1;
                end else if (TO != 0 && m_wait == TO - 1) begin
                    m_halt = 1'b1; m_bus = 1'b1;
                end else begin
                    m_wait++;
                end
                if (done) begin
                    m_wait = 0;
                    void'(plan.pop_front());
                    if (s.retires) begin m_ret = 1'b1; m_cnt++; end
                    if (s.is_decode) begin
                        expand(opcode, bad);
                        if (bad) begin m_halt = 1'b1; m_ill = 1'b1; end
                    end
                    if (plan.size() == 0) begin
                        plan.push_back(st("FETCH"));
                        plan.push_back(st("DECODE"));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        ctrl_t e;
        if (chk_en) begin
            e = '0;
            if (!m_halt && plan.size() > 0) begin
                e = plan[0].c;
                if (plan[0].is_fetch) begin
                    e.ir_write = mem_ready;
                    e.pc_write = mem_ready;
                end
            end
            check("ctrl", 32'(dut_c), 32'(e));
            check("retire", 32'(retire), 32'(m_ret));
            check("instret", 32'(instret), 32'(m_cnt % (1 << CW)));
            check("flags", {29'd0, trap, illegal_inst, bus_error},
                  {29'd0, m_halt, m_ill, m_bus});
        end
    end

    snap_t snap [0:15];

    function automatic snap_t sample();
        snap_t r;
        r.c = dut_c;
        r.retire = retire;
        r.instret = instret;
        r.trap = trap;
        r.ill = illegal_inst;
        r.bus = bus_error;
        return r;
    endfunction

    // snap[k] holds the outputs k edges after the call; low[k] stalls window k
    task automatic run(input logic [6:0] op, input int n,
                       input logic [15:0] low);
        opcode = op;
        snap[0] = sample();
        for (int i = 0; i < n; i++) begin
            mem_ready = ~low[i];
            @(posedge clk);
            #1;
            snap[i+1] = sample();
        end
        mem_ready = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_ctrl"}, 32'(dut_c), 32'd0);
        check({tag, "_flags"}, {29'd0, trap, illegal_inst, bus_error}, 32'd0);
        check({tag, "_cnt"}, {27'd0, retire, instret}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        run(7'b0110011, 5, 16'h0);
        check("rst_state", 32'(snap[0]), 32'd0);
        check("r_alu_op", 32'(snap[3].c.alu_op), 32'b010);
        check("r_wb", 32'(snap[4].c.reg_write), 32'd1);
        check("r_retire", {27'd0, snap[5].retire, snap[5].instret}, 32'h11);

        run(7'b0000011, 8, 16'b0011_1000);
        check("ld_hold",
              32'({snap[3].c.mem_read, snap[4].c.mem_read,
                   snap[5].c.mem_read, snap[6].c.mem_read,
                   snap[3].c.i_or_d, snap[6].c.i_or_d}), 32'h3f);
        check("ld_wb", 32'({snap[7].c.reg_write, snap[7].c.mem_to_reg}), 32'b101);
        check("ld_done", 32'({snap[8].trap, snap[8].instret}), 32'd2);

        run(7'b0110111, 4, 16'h0);
        check("lui", 32'({snap[2].c.alu_op, snap[2].c.src_a}), 32'b100_11);
        check("lui_cnt", 32'(snap[4].instret), 32'd3);
        run(7'b0010111, 4, 16'h0);
        check("auipc", 32'({snap[2].c.alu_op, snap[2].c.src_a}), 32'b101_10);
        check("auipc_cnt", 32'(snap[4].instret), 32'd4);

        run(7'b1100011, 3, 16'h0);
        check("br", 32'({snap[2].c.pc_write_cond, snap[2].c.pc_source,
                         snap[2].c.alu_op}), 32'b1_01_001);
        check("br_cnt", 32'(snap[3].instret), 32'd5);
        run(7'b1101111, 3, 16'h0);
        check("jal", 32'({snap[2].c.pc_write, snap[2].c.reg_write,
                          snap[2].c.mem_to_reg}), 32'b1_1_10);
        check("jal_cnt", 32'(snap[3].instret), 32'd6);

        run(7'b0100011, 4, 16'h0);
        check("st", 32'({snap[3].c.mem_write, snap[3].c.i_or_d}), 32'b11);
        check("st_cnt", 32'(snap[4].instret), 32'd7);
        run(7'b0010011, 4, 16'h0);
        check("exec_i", 32'(snap[2].c.alu_op), 32'b011);
        run(7'b1100111, 3, 16'h0);
        check("jalr", 32'({snap[2].c.pc_write, snap[2].c.src_a,
                           snap[2].c.pc_source}), 32'b1_01_00);
        check("jalr_cnt", 32'(snap[3].instret), 32'd9);

        for (int k = 0; k < 7; k++) run(7'b1100011, 3, 16'h0);
        check("wrap", 32'(snap[3].instret), 32'd0);
        run(7'b0110011, 4, 16'h0);
        check("wrap_p1", 32'(snap[4].instret), 32'd1);

        // ready arrives on the last allowed fetch cycle
        run(7'b0110011, 7, 16'b0111);
        check("near_dec", 32'({snap[4].trap, snap[4].c.src_a}), 32'b0_10);
        check("near_cnt", 32'({snap[7].trap, snap[7].instret}), 32'd2);

        run(7'b0110011, 14, 16'hffff);
        check("to_pre", 32'(snap[3].trap), 32'd0);
        check("to_trap", 32'({snap[4].trap, snap[4].ill, snap[4].bus}), 32'b101);
        check("to_hold", 32'({snap[14].c, snap[14].trap, snap[14].bus}),
              32'b11);
        do_reset("to_rst");

        run(7'b1111111, 13, 16'h0);
        check("ill_pre", 32'(snap[2].trap), 32'd0);
        check("ill_trap", 32'({snap[3].trap, snap[3].ill, snap[3].bus}), 32'b110);
        check("ill_hold", 32'({snap[13].c, snap[13].trap, snap[13].ill}),
              32'b11);
        do_reset("ill_rst");

        run(7'b0000011, 4, 16'b1000);
        check("abort_rd", 32'({snap[4].c.mem_read, snap[4].c.i_or_d}), 32'b11);
        do_reset("abort_rd_rst");

        run(7'b1101111, 3, 16'h0);
        check("abort_jal", 32'({snap[3].c.pc_write, snap[3].c.reg_write}), 32'b11);
        do_reset("abort_jal_rst");

        run(7'b0110011, 5, 16'h0);
        check("restart", 32'({snap[5].retire, snap[5].instret}), 32'h11);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
